ddr_burst_writer: RTL
=====================

// Module: ddr_burst_writer
// PURPOSE
//  Write-side DDR engine that serves the ddr1/ddr2 start/done handshake issued by the pe2ddr config stage.
//  - Takes one job: start address, bytes per burst, stride and burst count.
//  - Splits every burst into AXI4 write transactions (AW/W/B).
//  - Streams PE result beats from the data gatherer into W.
//  - Raises done once the last write response has returned.
// PARAMETERS
//  DATA_W      256  W-channel/in_data width in bits; BEAT_BYTES=DATA_W/8=32.
//  DDR_ADDR_W  32   DDR byte-address width.
//  BURST_W     16   width of burst / burst_num fields.
//  MAX_LEN     16   maximum beats per AXI transaction (awlen = beats-1).
//  MAX_OUTST   4    maximum AW transactions awaiting B.
// PORTS
//  clk         in   1           single clock; all logic on posedge.
//  rst_n       in   1           asynchronous, active-low reset.
//  start       in   1           1-cycle job request; sampled only while done=1.
//  done        out  1           level: 1 = idle/finished, 0 = job in flight.
//  st_addr     in   DDR_ADDR_W  byte address of first burst, 32B aligned.
//  burst       in   BURST_W     bytes per burst; low 5 bits ignored.
//  step        in   DDR_ADDR_W  byte stride between burst start addresses.
//  burst_num   in   BURST_W     number of bursts minus 1.
//  in_data     in   DATA_W      result beat from data gatherer.
//  in_valid    in   1           in_data valid.
//  in_ready    out  1           beat consumed.
//  m_awaddr    out  DDR_ADDR_W  AXI write address.
//  m_awlen     out  8           beats-1.
//  m_awvalid   out  1           AXI AW valid.
//  m_awready   in   1           AXI AW ready.
//  m_wdata     out  DATA_W      AXI write data.
//  m_wlast     out  1           last beat of transaction.
//  m_wvalid    out  1           AXI W valid.
//  m_wready    in   1           AXI W ready.
//  m_bvalid    in   1           write response valid; bresp is not checked.
//  m_bready    out  1           tied 1 while busy; 0 in IDLE.
// BEHAVIOUR
//  Reset: done=1, all valids 0, m_bready=0, m_awaddr=0, m_awlen=0, counters 0, state IDLE.
//    Reset mid-job aborts it silently; outstanding B responses are dropped.
//  Latching: start && done latches all fields; done falls the next cycle.
//    start while done=0 is ignored.
//  Job geometry:
//    beats_per_burst = burst>>5
//    bursts = burst_num+1
//    burst k begins at st_addr + k*step (running-sum adder, no multiplier).
//  Chunk size: len = min(remaining beats in burst, MAX_LEN, beats to next 4KB boundary).
//    No transaction crosses 4KB.
//  FSM:
//    IDLE -start-> CALC
//    CALC (1 cycle, registers len/addr) -> AW
//    AW: awvalid=1 until awready. Holds in CALC if outstanding==MAX_OUTST.
//        Handshake -> W.
//    W: after the final beat of a chunk:
//        more beats in burst -> CALC
//        next burst -> CALC
//        job end -> WAIT_B
//    WAIT_B: outstanding==0 -> IDLE with done=1 on the same edge.
//  W path is combinational passthrough, active only in W:
//    m_wdata=in_data
//    m_wvalid=in_valid
//    in_ready=m_wready
//    m_wlast=(beat_cnt==len-1)
//  Outstanding counter: +1 on AW handshake, -1 on B handshake.
//    Simultaneous +1/-1 leaves it unchanged.
//    m_bvalid while outstanding==0 is ignored (count saturates at 0).
//  burst>>5==0: skips AW/W entirely; done returns to 1 two cycles after start.
//  Address arithmetic wraps modulo 2^DDR_ADDR_W without error.
//  Latency: start to first m_awvalid = 2 cycles.
// STRUCTURE
//  GLOBAL_PARAM (shared package): DDR_ADDR_W, BURST_W, BEAT_BYTES, AXI_LEN_W=8, PAGE_BYTES=4096.
//  FSM state typedef stays local.
//  One sub-module, ddr_chunk_split: combinational min(remaining, MAX_LEN, 4KB-distance) -> len.
// TESTING
//  T1 st_addr=0x1000, burst=0x200, burst_num=0, MAX_LEN=16 -> one AW (0x1000, awlen=15), 16 W beats, wlast on 16th, done after B.
//  T2 burst=0x40, step=0x400, burst_num=2 -> AW addrs 0x1000/0x1400/0x1800, awlen=1 each, 3 B -> done.
//  T3 st_addr=0x1FC0, burst=0x100 -> AW 0x1FC0 awlen=1, then 0x2000 awlen=5 (4KB split).
//  T4 awready withheld 20 cycles, B withheld until MAX_OUTST reached -> awvalid held, no 5th AW, no lost beats.
//  T5 start during a job, and burst=0 job -> ignored; done=1 two cycles after start.
//  T6 rst_n low during W mid-transaction -> done=1, all valids 0 asynchronously; new job then runs cleanly.

Source files
------------

// File: rtl/ddr_burst_writer_pkg.sv
// Shared constants and job descriptor for the DDR write-side burst engine.
package ddr_burst_writer_pkg;

    localparam int DATA_W      = 256;
    localparam int DDR_ADDR_W  = 32;
    localparam int BURST_W     = 16;
    localparam int AXI_LEN_W   = 8;
    localparam int MAX_LEN     = 16;
    localparam int MAX_OUTST   = 4;

    localparam int BEAT_BYTES  = DATA_W / 8;
    localparam int BEAT_SHIFT  = $clog2(BEAT_BYTES);
    localparam int PAGE_BYTES  = 4096;
    localparam int PAGE_OFS_W  = $clog2(PAGE_BYTES);
    // Beat index inside a 4KB page, and a width that can also hold a full page of beats.
    localparam int PAGE_IDX_W  = PAGE_OFS_W - BEAT_SHIFT;
    localparam int PAGE_BEATS  = PAGE_BYTES / BEAT_BYTES;
    localparam int PAGE_BEAT_W = PAGE_IDX_W + 1;

    // Chunk length in beats (1..MAX_LEN), one bit wider than awlen.
    localparam int LEN_W       = AXI_LEN_W + 1;
    localparam int OUTST_W     = $clog2(MAX_OUTST + 1);

endpackage

// File: rtl/ddr_chunk_split.sv
// Picks the beat count of the next AXI write transaction: the smallest of the
// beats still owed to the current burst, the AXI length cap and the beats left
// before the next 4KB page boundary.
module ddr_chunk_split
    import ddr_burst_writer_pkg::*;
(
    input  logic [BURST_W-1:0]    remaining,
    input  logic [PAGE_IDX_W-1:0] page_beat,
    output logic [LEN_W-1:0]      len
);

    logic [PAGE_BEAT_W-1:0] page_left;
    logic [BURST_W-1:0]     cap;

    // Three-way minimum; page_left is never 0, so len >= 1 whenever remaining >= 1.
    always_comb begin
        page_left = PAGE_BEAT_W'(PAGE_BEATS) - PAGE_BEAT_W'(page_beat);
        cap       = (remaining < BURST_W'(MAX_LEN)) ? remaining : BURST_W'(MAX_LEN);
        if (BURST_W'(page_left) < cap) begin
            cap = BURST_W'(page_left);
        end
        len = LEN_W'(cap);
    end

endmodule

// File: rtl/ddr_burst_writer.sv
// Write-side DDR engine: takes one strided multi-burst job, cuts each burst into
// AXI4 write transactions that never cross 4KB, streams gatherer beats into W
// and reports done once every write response has come back.
module ddr_burst_writer
    import ddr_burst_writer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  done,
    input  logic [DDR_ADDR_W-1:0] st_addr,
    input  logic [BURST_W-1:0]    burst,
    input  logic [DDR_ADDR_W-1:0] step,
    input  logic [BURST_W-1:0]    burst_num,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DDR_ADDR_W-1:0] m_awaddr,
    output logic [AXI_LEN_W-1:0]  m_awlen,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_W-1:0]     m_wdata,
    output logic                  m_wlast,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic                  m_bvalid,
    output logic                  m_bready
);

    typedef enum logic [2:0] {S_IDLE, S_CALC, S_AW, S_W, S_WAIT_B} state_t;

    state_t                state_reg, state_next;
    logic [DDR_ADDR_W-1:0] addr_reg, base_reg, step_reg, awaddr_reg;
    logic [BURST_W-1:0]    bpb_reg, remain_reg, bursts_left_reg;
    logic [LEN_W-1:0]      len_reg, beat_cnt_reg;
    logic [AXI_LEN_W-1:0]  awlen_reg;
    logic [OUTST_W-1:0]    outst_reg;

    logic [LEN_W-1:0]      chunk_len;
    logic [BURST_W-1:0]    remain_after;
    logic [DDR_ADDR_W-1:0] next_base;
    logic                  outst_full, aw_hs, w_hs, b_hs, last_beat;
    logic                  unused_bits;

    // Sub-beat bits of the burst size carry no information.
    assign unused_bits  = ^burst[BEAT_SHIFT-1:0];

    assign outst_full   = (outst_reg == OUTST_W'(MAX_OUTST));
    assign aw_hs        = (state_reg == S_AW) && m_awready;
    assign w_hs         = (state_reg == S_W) && in_valid && m_wready;
    assign b_hs         = m_bvalid && m_bready && (outst_reg != '0);
    assign last_beat    = (beat_cnt_reg == len_reg - LEN_W'(1));
    assign remain_after = remain_reg - BURST_W'(len_reg);
    assign next_base    = base_reg + step_reg;

    assign m_awaddr     = awaddr_reg;
    assign m_awlen      = awlen_reg;
    assign m_wdata      = in_data;

    ddr_chunk_split u_split (
        .remaining (remain_reg),
        .page_beat (addr_reg[PAGE_OFS_W-1:BEAT_SHIFT]),
        .len       (chunk_len)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: one CALC/AW/W pass per chunk, then drain responses.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (start) state_next = S_CALC;
            S_CALC: begin
                if (bpb_reg == '0) begin
                    state_next = S_IDLE;
                end else if (!outst_full) begin
                    state_next = S_AW;
                end
            end
            S_AW:     if (m_awready) state_next = S_W;
            S_W: begin
                if (w_hs && last_beat) begin
                    if (remain_after != '0 || bursts_left_reg != '0) begin
                        state_next = S_CALC;
                    end else begin
                        state_next = S_WAIT_B;
                    end
                end
            end
            S_WAIT_B: if (outst_reg == '0) state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Outputs: W channel is a straight passthrough gated to the W state.
    always_comb begin
        done      = (state_reg == S_IDLE);
        m_awvalid = (state_reg == S_AW);
        m_bready  = (state_reg != S_IDLE);
        m_wvalid  = 1'b0;
        in_ready  = 1'b0;
        m_wlast   = 1'b0;
        if (state_reg == S_W) begin
            m_wvalid = in_valid;
            in_ready = m_wready;
            m_wlast  = last_beat;
        end
    end

    // Job latch, chunk registration and address walking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_reg        <= '0;
            base_reg        <= '0;
            step_reg        <= '0;
            awaddr_reg      <= '0;
            bpb_reg         <= '0;
            remain_reg      <= '0;
            bursts_left_reg <= '0;
            len_reg         <= '0;
            beat_cnt_reg    <= '0;
            awlen_reg       <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        addr_reg        <= st_addr;
                        base_reg        <= st_addr;
                        step_reg        <= step;
                        bpb_reg         <= burst >> BEAT_SHIFT;
                        remain_reg      <= burst >> BEAT_SHIFT;
                        bursts_left_reg <= burst_num;
                    end
                end
                S_CALC: begin
                    if (bpb_reg != '0 && !outst_full) begin
                        len_reg      <= chunk_len;
                        awaddr_reg   <= addr_reg;
                        awlen_reg    <= AXI_LEN_W'(chunk_len - LEN_W'(1));
                        beat_cnt_reg <= '0;
                    end
                end
                S_W: begin
                    if (w_hs) begin
                        beat_cnt_reg <= beat_cnt_reg + LEN_W'(1);
                        if (last_beat) begin
                            if (remain_after != '0) begin
                                addr_reg   <= addr_reg + (DDR_ADDR_W'(len_reg) << BEAT_SHIFT);
                                remain_reg <= remain_after;
                            end else if (bursts_left_reg != '0) begin
                                // Running-sum stride: next burst starts one step past the last base.
                                base_reg        <= next_base;
                                addr_reg        <= next_base;
                                remain_reg      <= bpb_reg;
                                bursts_left_reg <= bursts_left_reg - BURST_W'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Transactions awaiting B: +1 per AW, -1 per accepted B, never below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst_reg <= '0;
        end else begin
            case ({aw_hs, b_hs})
                2'b10:   outst_reg <= outst_reg + OUTST_W'(1);
                2'b01:   outst_reg <= outst_reg - OUTST_W'(1);
                default: ;
            endcase
        end
    end

endmodule
